// File: rtl/enigma_pkg.sv
// Shared constants and types for the enigma message capture block.
//   SYMB_W    : width of one encoded symbol
//   ADDR_W    : message buffer address width
//   DEPTH     : buffer entries (2**ADDR_W)
//   ALPH_SIZE : legal symbol codes are 0..ALPH_SIZE-1
package enigma_pkg;

    localparam int unsigned SYMB_W    = 6;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned ALPH_SIZE = 26;

    typedef logic [SYMB_W-1:0] symb_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } cap_state_e;

endpackage

// File: rtl/enigma_msg_ram.sv
// DEPTH x SYMB_W message buffer: one synchronous write port, one registered read port.
// A read of the address being written in the same cycle returns the new symbol.
//   clk     : clock
//   we      : write enable
//   addr    : write address
//   data    : write data
//   rd_en   : read enable; data_o holds when low
//   rd_addr : read address
//   data_o  : registered read data
module enigma_msg_ram
    import enigma_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  symb_t             data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output symb_t             data_o
);

    symb_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= data;
        end
        if (rd_en) begin
            data_o <= (we && (addr == rd_addr)) ? data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/enigma_msg_capture.sv
// Captures the encoded symbol stream from enigma_1 into a message buffer and
// exposes a registered read port for reading the message back by address.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous reset, active low
//   start_i     : pulse; latch symb_numb, clear status, begin capture
//   symb_numb   : message length in symbols (0 goes straight to DONE)
//   sym_valid_i : sym_i carries a symbol
//   sym_i       : encoded symbol
//   rd_en_i     : read request
//   rd_addr_i   : read address
//   rd_data_o   : read data, one cycle after rd_en_i; 0 beyond captured count
//   rd_valid_o  : rd_data_o valid
//   busy_o      : capturing
//   done_o      : message complete
//   count_o     : symbols captured in the current message
//   overflow_o  : sticky, symbol arrived after the message completed
//   illegal_o   : sticky, a captured symbol was outside the alphabet
module enigma_msg_capture
    import enigma_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] symb_numb,
    input  logic              sym_valid_i,
    input  symb_t             sym_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output symb_t             rd_data_o,
    output logic              rd_valid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] count_o,
    output logic              overflow_o,
    output logic              illegal_o
);

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              overflow_q, overflow_d;
    logic              illegal_q, illegal_d;
    logic              rd_valid_q;
    logic              rd_hit_q, rd_hit_d;
    logic              wr_en;
    symb_t             ram_data;

    // A symbol coinciding with start_i belongs to neither message and is dropped.
    assign wr_en = (state_q == CAPTURE) && sym_valid_i && !start_i;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        target_d   = target_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;

        if (start_i) begin
            count_d    = '0;
            overflow_d = 1'b0;
            illegal_d  = 1'b0;
            target_d   = symb_numb;
            state_d    = (symb_numb != '0) ? CAPTURE : DONE;
        end else begin
            unique case (state_q)
                IDLE: ;
                CAPTURE: begin
                    if (sym_valid_i) begin
                        count_d = count_q + 1'b1;
                        if (sym_i >= SYMB_W'(ALPH_SIZE)) begin
                            illegal_d = 1'b1;
                        end
                        if (count_q + 1'b1 == target_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (sym_valid_i) begin
                        overflow_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Address is readable if already captured, or being captured this very cycle
    // (pairs with the RAM's write-first bypass).
    always_comb begin
        rd_hit_d = rd_hit_q;
        if (rd_en_i) begin
            rd_hit_d = (rd_addr_i < count_q) || (wr_en && (rd_addr_i == count_q));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            target_q   <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            target_q   <= target_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
            rd_valid_q <= rd_en_i;
            rd_hit_q   <= rd_hit_d;
        end
    end

    enigma_msg_ram u_ram (
        .clk     (clk_i),
        .we      (wr_en),
        .addr    (count_q),
        .data    (sym_i),
        .rd_en   (rd_en_i),
        .rd_addr (rd_addr_i),
        .data_o  (ram_data)
    );

    // Buffer is not reset, so gating with the registered hit flag keeps stale or
    // uninitialised entries off the output; both registers hold while rd_en_i is low.
    assign rd_data_o  = rd_hit_q ? ram_data : '0;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = (state_q == CAPTURE);
    assign done_o     = (state_q == DONE);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_enigma_msg_capture.sv
// Directed self-checking bench for enigma_msg_capture.
module tb_enigma_msg_capture;
    import enigma_pkg::*;

    logic              clk;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W-1:0] symb_numb;
    logic              sym_valid_i;
    symb_t             sym_i;
    logic              rd_en_i;
    logic [ADDR_W-1:0] rd_addr_i;
    symb_t             rd_data_o;
    logic              rd_valid_o;
    logic              busy_o;
    logic              done_o;
    logic [ADDR_W-1:0] count_o;
    logic              overflow_o;
    logic              illegal_o;

    int n_vec = 0;
    int n_err = 0;

    enigma_msg_capture dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .symb_numb   (symb_numb),
        .sym_valid_i (sym_valid_i),
        .sym_i       (sym_i),
        .rd_en_i     (rd_en_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .illegal_o   (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int n);
        start_i   = 1'b1;
        symb_numb = ADDR_W'(n);
        tick();
        start_i   = 1'b0;
    endtask

    task automatic send(input int s);
        sym_valid_i = 1'b1;
        sym_i       = SYMB_W'(s);
        tick();
        sym_valid_i = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int addr, input int exp);
        rd_en_i   = 1'b1;
        rd_addr_i = ADDR_W'(addr);
        tick();
        rd_en_i   = 1'b0;
        check_eq({tag, "_valid"}, 32'(rd_valid_o), 1);
        check_eq({tag, "_data"}, 32'(rd_data_o), 32'(exp));
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_o), 0);
        check_eq({tag, "_done"}, 32'(done_o), 0);
        check_eq({tag, "_count"}, 32'(count_o), 0);
        check_eq({tag, "_ovf"}, 32'(overflow_o), 0);
        check_eq({tag, "_ill"}, 32'(illegal_o), 0);
        check_eq({tag, "_rdv"}, 32'(rd_valid_o), 0);
        check_eq({tag, "_rdd"}, 32'(rd_data_o), 0);
    endtask

    initial begin
        rst_i       = 1'b0;
        start_i     = 1'b0;
        symb_numb   = '0;
        sym_valid_i = 1'b0;
        sym_i       = '0;
        rd_en_i     = 1'b0;
        rd_addr_i   = '0;
        tick();
        tick();
        rst_i = 1'b1;
        check_idle_zero("reset");

        // 1: two-symbol message, readback
        start(2);
        check_eq("t1_busy", 32'(busy_o), 1);
        send(5);
        check_eq("t1_done_early", 32'(done_o), 0);
        send(9);
        check_eq("t1_done", 32'(done_o), 1);
        check_eq("t1_busy_off", 32'(busy_o), 0);
        check_eq("t1_count", 32'(count_o), 2);
        read_chk("t1_rd2", 2, 0);
        read_chk("t1_rd0", 0, 5);
        read_chk("t1_rd1", 1, 9);
        tick();
        check_eq("t1_rdv_drop", 32'(rd_valid_o), 0);
        check_eq("t1_rd_hold", 32'(rd_data_o), 9);

        // 2: gap in stream, then overflow in DONE
        start(3);
        send(1);
        send(2);
        tick();
        check_eq("t2_gap_count", 32'(count_o), 2);
        check_eq("t2_gap_busy", 32'(busy_o), 1);
        send(3);
        check_eq("t2_done", 32'(done_o), 1);
        send(20);
        send(21);
        check_eq("t2_count", 32'(count_o), 3);
        check_eq("t2_ovf", 32'(overflow_o), 1);
        check_eq("t2_done_hold", 32'(done_o), 1);
        read_chk("t2_rd0", 0, 1);
        read_chk("t2_rd1", 1, 2);
        read_chk("t2_rd2", 2, 3);
        read_chk("t2_rd3", 3, 0);

        // 3: out-of-alphabet symbol
        start(1);
        check_eq("t3_ovf_clr", 32'(overflow_o), 0);
        send(25);
        check_eq("t3_ill_25", 32'(illegal_o), 0);
        start(1);
        send(40);
        check_eq("t3_ill", 32'(illegal_o), 1);
        read_chk("t3_rd0", 0, 40);
        start(1);
        check_eq("t3_ill_clr", 32'(illegal_o), 0);

        // 4: restart mid-message; symbol coincident with start is dropped
        start(4);
        send(7);
        send(8);
        start_i     = 1'b1;
        symb_numb   = 4'd1;
        sym_valid_i = 1'b1;
        sym_i       = 6'd63;
        tick();
        start_i = 1'b0;
        sym_valid_i = 1'b0;
        check_eq("t4_restart_count", 32'(count_o), 0);
        check_eq("t4_restart_ill", 32'(illegal_o), 0);
        send(11);
        check_eq("t4_done", 32'(done_o), 1);
        check_eq("t4_count", 32'(count_o), 1);
        read_chk("t4_rd0", 0, 11);
        read_chk("t4_rd1", 1, 0);

        // 5: reset mid-capture
        start(5);
        send(1);
        send(2);
        send(3);
        read_chk("t5_rd_cap", 0, 1);
        check_eq("t5_busy", 32'(busy_o), 1);
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        check_idle_zero("t5_rst");
        send(4);
        send(4);
        check_eq("t5_idle_ovf", 32'(overflow_o), 0);
        check_eq("t5_idle_count", 32'(count_o), 0);
        check_eq("t5_idle_busy", 32'(busy_o), 0);
        read_chk("t5_rd0", 0, 0);

        // 6: zero-length message, then same-cycle write/read bypass
        start(0);
        check_eq("t6_done", 32'(done_o), 1);
        check_eq("t6_busy", 32'(busy_o), 0);
        check_eq("t6_count", 32'(count_o), 0);
        start(2);
        rd_en_i   = 1'b1;
        rd_addr_i = 4'd0;
        send(17);
        check_eq("t6_byp0_valid", 32'(rd_valid_o), 1);
        check_eq("t6_byp0_data", 32'(rd_data_o), 17);
        rd_addr_i = 4'd1;
        send(18);
        rd_en_i = 1'b0;
        check_eq("t6_byp1_data", 32'(rd_data_o), 18);
        check_eq("t6_done2", 32'(done_o), 1);
        read_chk("t6_rd0", 0, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/enigma_msg_capture.md
Name: enigma_msg_capture

Overview:
- Receive-side counterpart to enigma_wrapper's symbol source and default-RAM write port.
- Collects the encoded 6-bit symbol stream from enigma_1 into a message buffer of symb_numb symbols.
- Flags framing and alphabet errors, and exposes a registered read port so a host or bench can read the captured message back by address.
- Sits downstream of enigma_1's out_symb_o in the full enigma top.

Parameters:
SYMB_W, 6, symbol width (matches enigma symbol bus)
ADDR_W, 4, buffer address width (matches symb_numb width)
DEPTH, 16, buffer entries, equals 2**ADDR_W
ALPH_SIZE, 26, legal symbol codes are 0..ALPH_SIZE-1

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-low
start_i  in  1  one-cycle pulse: latch symb_numb, clear status, begin capture
symb_numb  in  ADDR_W  message length in symbols, sampled only on start_i
sym_valid_i  in  1  sym_i carries a symbol this cycle
sym_i  in  SYMB_W  encoded symbol from enigma_1
rd_en_i  in  1  read request
rd_addr_i  in  ADDR_W  read address
rd_data_o  out  SYMB_W  read data, registered
rd_valid_o  out  1  rd_data_o valid, one cycle after rd_en_i
busy_o  out  1  high in CAPTURE
done_o  out  1  high in DONE
count_o  out  ADDR_W  symbols captured in the current message
overflow_o  out  1  sticky: symbol arrived while in DONE
illegal_o  out  1  sticky: captured symbol >= ALPH_SIZE

Behaviour:
- Reset: when rst_i==0 at a clock edge, go to IDLE. busy_o, done_o, rd_valid_o, overflow_o and illegal_o go to 0. count_o and rd_data_o go to 0. The write pointer and latched length clear. Buffer contents are not reset.
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - start_i with symb_numb!=0 -> CAPTURE, target <= symb_numb.
  - start_i with symb_numb==0 -> DONE directly, count 0.
  - sym_valid_i is ignored and sets no flag.
- CAPTURE:
  - Each sym_valid_i cycle: mem[count] <= sym_i, count increments.
  - If sym_i >= ALPH_SIZE, the symbol is still stored and illegal_o is set.
  - The cycle in which the accepted symbol makes count == target -> DONE on the next edge. done_o is high the cycle after the last symbol is sampled.
- DONE:
  - Holds until start_i.
  - sym_valid_i sets overflow_o; the symbol is dropped and count is unchanged.
- start_i in any state (including mid-CAPTURE):
  - Restart: count <= 0; overflow_o and illegal_o clear; new target latched.
  - A sym_valid_i in the same cycle as start_i is dropped.
- Count width: count never exceeds target (max 15), so it never wraps. DEPTH entry 15 is addressable; length 16 is not supported.
- Reads:
  - Allowed in every state, including during CAPTURE.
  - Latency 1: rd_valid_o <= rd_en_i.
  - rd_addr_i < count -> rd_data_o <= mem[rd_addr_i]. Otherwise rd_data_o <= 0 (never stale data).
  - Write and read to the same address in the same cycle return the new symbol (write-first bypass).
  - rd_data_o holds its last value when rd_en_i==0.
- Reset mid-capture: abandons the message immediately. Reads after reset return 0 because count is 0.

Decomposition:
- Package enigma_pkg holds:
  - SYMB_W, ADDR_W, ALPH_SIZE constants;
  - typedef logic [SYMB_W-1:0] symb_t;
  - typedef enum {IDLE, CAPTURE, DONE} cap_state_e.
- One sub-module: enigma_msg_ram, a DEPTH x SYMB_W single-write/single-read synchronous RAM with write-first bypass. Its port style mirrors the default RAM (we, data, addr, data_o).
- The FSM, counters and flags stay in the top module.

Test Plan:
1. Reset, start_i with symb_numb=2, symbols 5 then 9 on consecutive cycles:
   - done_o rises the cycle after 9; count_o=2.
   - Reads of addr 0/1 -> 5/9 one cycle later with rd_valid_o=1; addr 2 -> 0.
2. symb_numb=3, symbols 1,2 (gap) 3, then two more symbols in DONE:
   - count_o=3, overflow_o=1, buffer contents unchanged.
3. Capture with symbol 6'd40, ALPH_SIZE=26:
   - illegal_o=1; read returns 40.
   - A following start_i clears illegal_o.
4. Restart mid-message: symb_numb=4, two symbols 7,8, then start_i with symb_numb=1 and symbol 11:
   - done_o=1, count_o=1; addr0 reads 11, addr1 reads 0.
5. rst_i=0 for one cycle mid-CAPTURE after 3 of 5 symbols:
   - All outputs 0, state IDLE.
   - Symbols in IDLE are ignored (overflow_o stays 0).
6. symb_numb=0 start:
   - done_o the next cycle, busy_o never high, count_o=0.
   - Same-cycle write/read of addr 0 during a separate capture returns the written symbol.
